// File: rtl/des_pkg.sv
// Shared DES definitions for the CBC front end: FSM states, block width, direction flags.
package des_pkg;

  localparam int unsigned DES_W = 64;

  localparam logic FLAG_ENC = 1'b1;
  localparam logic FLAG_DEC = 1'b0;

  typedef logic [DES_W-1:0] blk_t;

  typedef enum logic [1:0] {
    NOKEY   = 2'd0,
    KEYWAIT = 2'd1,
    READY   = 2'd2,
    BUSY    = 2'd3
  } cbc_state_t;

endpackage

// File: rtl/des_cbc_ctrl_if.sv
// Upstream block source / downstream result bus of des_cbc_ctrl.
interface des_cbc_ctrl_if;
    import des_pkg::*;

    logic i_flag;
    blk_t i_din;
    logic i_din_en;
    logic o_din_rdy;
    blk_t o_dout;
    logic o_dout_en;

    modport master (
        output i_flag, i_din, i_din_en,
        input  o_din_rdy, o_dout, o_dout_en
    );

    modport slave (
        input  i_flag, i_din, i_din_en,
        output o_din_rdy, o_dout, o_dout_en
    );

endinterface

// File: rtl/des_cbc_ctrl.sv
// CBC chaining front end for des_core: one block in flight, IV/chain register, result strobe.
// Optional ECB bypass (i_ecb port) when DES_CBC_ECB_EN is defined.
module des_cbc_ctrl
    import des_pkg::*;
#(
    parameter int DLY = 1
) (
    input  logic                 r_clk,
    input  logic                 r_rst,
    input  blk_t                 i_key,
    input  logic                 i_key_en,
    input  blk_t                 i_iv,
    input  logic                 i_iv_en,
`ifdef DES_CBC_ECB_EN
    input  logic                 i_ecb,
`endif
    des_cbc_ctrl_if.slave        bus,
    output blk_t                 o_core_key,
    output logic                 o_core_key_en,
    output logic                 o_core_flag,
    output blk_t                 o_core_din,
    output logic                 o_core_din_en,
    input  blk_t                 i_core_dout,
    input  logic                 i_core_dout_en,
    input  logic                 i_core_key_ok
);

    if (DLY < 0) begin : g_dly_chk
        $error("des_cbc_ctrl: DLY must be non-negative");
    end

    cbc_state_t state, state_nxt;
    logic       din_rdy;
    logic       accept;
    logic       complete;
    logic       iv_load;
    logic       ecb_in;
    logic       blk_ecb;
    blk_t       chain;
    blk_t       chain_src;
    blk_t       saved_ct;

`ifdef DES_CBC_ECB_EN
    assign ecb_in = i_ecb;
`else
    assign ecb_in = 1'b0;
`endif

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) state <= NOKEY;
        else       state <= state_nxt;
    end

    // A key load overrides everything, abandoning any in-flight block.
    // KEYWAIT ignores key_ok while the key strobe is still on its way to the core.
    always_comb begin
        state_nxt = state;
        din_rdy   = 1'b0;
        accept    = 1'b0;
        complete  = 1'b0;
        unique case (state)
            NOKEY: ;
            KEYWAIT: begin
                if (i_core_key_ok && !o_core_key_en) state_nxt = READY;
            end
            READY: begin
                din_rdy = 1'b1;
                accept  = bus.i_din_en;
                if (accept) state_nxt = BUSY;
            end
            BUSY: begin
                complete = i_core_dout_en;
                if (complete) state_nxt = READY;
            end
            default: ;
        endcase
        if (i_key_en) begin
            state_nxt = KEYWAIT;
            accept    = 1'b0;
            complete  = 1'b0;
        end
    end

    assign bus.o_din_rdy = din_rdy;

    // A same-cycle IV load takes effect before the XOR of the accepted block.
    always_comb begin
        iv_load   = i_iv_en && (state != BUSY);
        chain_src = iv_load ? i_iv : chain;
    end

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            o_core_key    <= '0;
            o_core_key_en <= 1'b0;
            o_core_flag   <= 1'b0;
            o_core_din    <= '0;
            o_core_din_en <= 1'b0;
            bus.o_dout    <= '0;
            bus.o_dout_en <= 1'b0;
            chain         <= '0;
            saved_ct      <= '0;
            blk_ecb       <= 1'b0;
        end else begin
            o_core_key_en <= 1'b0;
            o_core_din_en <= 1'b0;
            bus.o_dout_en <= 1'b0;

            if (i_key_en) begin
                o_core_key    <= i_key;
                o_core_key_en <= 1'b1;
            end

            if (iv_load) chain <= i_iv;

            if (accept) begin
                o_core_din_en <= 1'b1;
                o_core_flag   <= bus.i_flag;
                blk_ecb       <= ecb_in;
                if (bus.i_flag == FLAG_ENC && !ecb_in) o_core_din <= bus.i_din ^ chain_src;
                else                                    o_core_din <= bus.i_din;
                if (bus.i_flag == FLAG_DEC) saved_ct <= bus.i_din;
            end

            if (complete) begin
                bus.o_dout_en <= 1'b1;
                if (blk_ecb) begin
                    bus.o_dout <= i_core_dout;
                end else if (o_core_flag == FLAG_DEC) begin
                    bus.o_dout <= i_core_dout ^ chain;
                    chain      <= saved_ct;
                end else begin
                    bus.o_dout <= i_core_dout;
                    chain      <= i_core_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Self-checking bench for des_cbc_ctrl with a behavioural des_core stand-in and a result scoreboard.
module tb_des_cbc_ctrl;
    import des_pkg::*;

    localparam int unsigned CORE_LAT  = 3;
    localparam int unsigned KEYOK_DLY = 4;
    localparam blk_t K0  = 64'hAABB09182736CCDD;
    localparam blk_t P0  = 64'h123456ABCD132536;
    localparam blk_t P1  = 64'hD283FE7B9229A7AA;
    localparam blk_t C0  = 64'hC0B7A8D05F3A829C;
    localparam blk_t IVX = 64'h0F1E2D3C4B5A6978;

    logic r_clk = 1'b0;
    logic r_rst;
    blk_t i_key;
    logic i_key_en;
    blk_t i_iv;
    logic i_iv_en;
`ifdef DES_CBC_ECB_EN
    logic i_ecb;
`endif
    blk_t o_core_key;
    logic o_core_key_en;
    logic o_core_flag;
    blk_t o_core_din;
    logic o_core_din_en;
    blk_t i_core_dout;
    logic i_core_dout_en;
    logic i_core_key_ok;

    des_cbc_ctrl_if bus ();

    des_cbc_ctrl #(.DLY(1)) dut (
        .r_clk          (r_clk),
        .r_rst          (r_rst),
        .i_key          (i_key),
        .i_key_en       (i_key_en),
        .i_iv           (i_iv),
        .i_iv_en        (i_iv_en),
`ifdef DES_CBC_ECB_EN
        .i_ecb          (i_ecb),
`endif
        .bus            (bus),
        .o_core_key     (o_core_key),
        .o_core_key_en  (o_core_key_en),
        .o_core_flag    (o_core_flag),
        .o_core_din     (o_core_din),
        .o_core_din_en  (o_core_din_en),
        .i_core_dout    (i_core_dout),
        .i_core_dout_en (i_core_dout_en),
        .i_core_key_ok  (i_core_key_ok)
    );

    always #5 r_clk = ~r_clk;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned n_strobes = 0;
    int unsigned cyc = 0;

    always @(posedge r_clk) cyc <= cyc + 1;

    task automatic check64(input string nm, input blk_t act, input blk_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_int(input string nm, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // ---------------- des_core stand-in: exact for the reference vector, invertible otherwise
    function automatic blk_t core_enc(blk_t k, blk_t x);
        if (k == K0 && x == P0) return C0;
        return {x[55:0], x[63:56]} ^ k;
    endfunction

    function automatic blk_t core_dec(blk_t k, blk_t y);
        blk_t t;
        if (k == K0 && y == C0) return P0;
        t = y ^ k;
        return {t[7:0], t[63:8]};
    endfunction

    blk_t                core_key_m;
    logic [CORE_LAT-1:0] vpipe;
    blk_t                dpipe [CORE_LAT];
    int unsigned         kcnt;
    logic                spur = 1'b0;

    always @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            vpipe         <= '0;
            kcnt          <= 0;
            i_core_key_ok <= 1'b0;
            core_key_m    <= '0;
            for (int i = 0; i < CORE_LAT; i++) dpipe[i] <= '0;
        end else begin
            vpipe    <= {vpipe[CORE_LAT-2:0], o_core_din_en};
            dpipe[0] <= o_core_flag ? core_enc(core_key_m, o_core_din) : core_dec(core_key_m, o_core_din);
            for (int i = 1; i < CORE_LAT; i++) dpipe[i] <= dpipe[i-1];
            if (o_core_key_en) begin
                core_key_m    <= o_core_key;
                i_core_key_ok <= 1'b0;
                kcnt          <= KEYOK_DLY;
            end else if (kcnt != 0) begin
                kcnt <= kcnt - 1;
                if (kcnt == 1) i_core_key_ok <= 1'b1;
            end
        end
    end

    assign i_core_dout_en = vpipe[CORE_LAT-1] | spur;
    assign i_core_dout    = dpipe[CORE_LAT-1];

    // ---------------- scoreboard
    typedef struct {
        blk_t        exp;
        int unsigned acc_cyc;
        string       name;
    } sb_t;

    sb_t sbq[$];
    sb_t sb_head;

    always @(negedge r_clk) begin
        if (!r_rst) begin
            if (bus.o_dout_en) begin
                n_strobes++;
                if (sbq.size() == 0) begin
                    check_int("unexpected_dout_en", 32'(bus.o_dout_en), 0);
                end else begin
                    sb_head = sbq.pop_front();
                    check64({sb_head.name, "_dout"}, bus.o_dout, sb_head.exp);
                    check_int({sb_head.name, "_latency"}, cyc - sb_head.acc_cyc, CORE_LAT + 2);
                end
            end else if (sbq.size() != 0 && cyc > sbq[0].acc_cyc) begin
                check_int({sbq[0].name, "_rdy_low_busy"}, 32'(bus.o_din_rdy), 0);
            end
        end
    end

    // ---------------- driver tasks (enter and leave on a falling edge)
    task automatic load_key(input blk_t k);
        i_key    = k;
        i_key_en = 1'b1;
        @(negedge r_clk);
        i_key_en = 1'b0;
    endtask

    task automatic send(input string nm, input logic iv_en, input blk_t iv, input logic flag,
                        input blk_t din, input logic ecb, input logic want, input blk_t exp);
        int unsigned t;
        t = 0;
        while (!bus.o_din_rdy && t < 60) begin
            @(negedge r_clk);
            t++;
        end
        if (!bus.o_din_rdy) begin
            check_int({nm, "_rdy_timeout"}, 32'(bus.o_din_rdy), 1);
            return;
        end
        i_iv_en      = iv_en;
        i_iv         = iv;
        bus.i_flag   = flag;
        bus.i_din    = din;
        bus.i_din_en = 1'b1;
`ifdef DES_CBC_ECB_EN
        i_ecb        = ecb;
`else
        if (ecb) $display("note: ecb request ignored in CBC-only build");
`endif
        if (want) sbq.push_back('{exp, cyc, nm});
        @(negedge r_clk);
        bus.i_din_en = 1'b0;
        i_iv_en      = 1'b0;
        if (want) begin
            t = 0;
            while (sbq.size() != 0 && t < 100) begin
                @(negedge r_clk);
                t++;
            end
            if (sbq.size() != 0) begin
                check_int({nm, "_result_timeout"}, sbq.size(), 0);
                sbq.delete();
            end
        end
    endtask

    // ---------------- stimulus
    typedef struct {
        string nm;
        logic  iv_en;
        blk_t  iv;
        logic  flag;
        blk_t  din;
        blk_t  exp;
    } vec_t;

    vec_t vecs[6];
    blk_t rp[4];
    blk_t rc[4];
    blk_t m;
    blk_t riv;
    int unsigned s0;

    initial begin
        vecs[0] = '{"enc_p0_iv0",  1'b1, '0,  FLAG_ENC, P0,       C0};
        vecs[1] = '{"enc_p1_chain", 1'b0, '0,  FLAG_ENC, P1,       C0};
        vecs[2] = '{"dec_c0_iv0",  1'b1, '0,  FLAG_DEC, C0,       P0};
        vecs[3] = '{"dec_c0_chain", 1'b0, '0,  FLAG_DEC, C0,       P1};
        vecs[4] = '{"enc_ivx",     1'b1, IVX, FLAG_ENC, P0 ^ IVX, C0};
        vecs[5] = '{"dec_ivx",     1'b1, IVX, FLAG_DEC, C0,       P0 ^ IVX};

        r_rst = 1'b1;
        i_key = '0; i_key_en = 1'b0; i_iv = '0; i_iv_en = 1'b0;
        bus.i_flag = 1'b0; bus.i_din = '0; bus.i_din_en = 1'b0;
`ifdef DES_CBC_ECB_EN
        i_ecb = 1'b0;
`endif
        @(negedge r_clk);
        @(negedge r_clk);
        check_int("reset_rdy", 32'(bus.o_din_rdy), 0);
        check_int("reset_dout_en", 32'(bus.o_dout_en), 0);
        check64("reset_dout", bus.o_dout, '0);
        check64("reset_core_din", o_core_din, '0);
        check64("reset_core_key", o_core_key, '0);
        check_int("reset_core_strobes", {29'd0, o_core_key_en, o_core_din_en, o_core_flag}, 0);
        r_rst = 1'b0;

        // Blocks offered with no key loaded are dropped.
        bus.i_din    = P0;
        bus.i_din_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge r_clk);
            check_int("nokey_drop_core_din_en", 32'(o_core_din_en), 0);
        end
        bus.i_din_en = 1'b0;

        load_key(K0);
        check_int("keywait_rdy", 32'(bus.o_din_rdy), 0);
        check_int("core_key_en_pulse", 32'(o_core_key_en), 1);
        check64("core_key", o_core_key, K0);

        for (int i = 0; i < 6; i++)
            send(vecs[i].nm, vecs[i].iv_en, vecs[i].iv, vecs[i].flag, vecs[i].din, 1'b0, 1'b1, vecs[i].exp);

        repeat (3) @(negedge r_clk);
        check64("dout_hold", bus.o_dout, P0 ^ IVX);

        // Core strobe outside BUSY must not produce a result.
        s0   = n_strobes;
        spur = 1'b1;
        @(negedge r_clk);
        spur = 1'b0;
        repeat (3) @(negedge r_clk);
        check_int("spurious_core_dout_ignored", n_strobes - s0, 0);

        // Random CBC round trip with direction switch at the IV reload.
        riv = {$urandom, $urandom};
        m   = riv;
        for (int i = 0; i < 4; i++) begin
            rp[i] = {$urandom, $urandom};
            rc[i] = core_enc(K0, rp[i] ^ m);
            m     = rc[i];
            send("rnd_enc", i == 0, riv, FLAG_ENC, rp[i], 1'b0, 1'b1, rc[i]);
        end
        for (int i = 0; i < 4; i++)
            send("rnd_dec", i == 0, riv, FLAG_DEC, rc[i], 1'b0, 1'b1, rp[i]);

        // Key reload while BUSY abandons the block.
        s0 = n_strobes;
        send("abandon", 1'b0, '0, FLAG_ENC, P1, 1'b0, 1'b0, '0);
        load_key(K0);
        check_int("abandon_keywait_rdy", 32'(bus.o_din_rdy), 0);
        send("after_abandon", 1'b1, '0, FLAG_ENC, P0, 1'b0, 1'b1, C0);
        check_int("abandon_strobe_count", n_strobes - s0, 1);

        // Asynchronous reset in the middle of a block.
        send("rst_victim", 1'b0, '0, FLAG_ENC, P1, 1'b0, 1'b0, '0);
        #2 r_rst = 1'b1;
        #1;
        check_int("midrst_rdy", 32'(bus.o_din_rdy), 0);
        check_int("midrst_dout_en", 32'(bus.o_dout_en), 0);
        check64("midrst_dout", bus.o_dout, '0);
        check64("midrst_core_din", o_core_din, '0);
        check64("midrst_core_key", o_core_key, '0);
        check_int("midrst_core_strobes", {29'd0, o_core_key_en, o_core_din_en, o_core_flag}, 0);
        @(negedge r_clk);
        r_rst = 1'b0;
        repeat (6) @(negedge r_clk);
        check_int("postrst_rdy_without_key", 32'(bus.o_din_rdy), 0);
        load_key(K0);
        send("postrst_chain_zero", 1'b0, '0, FLAG_ENC, P0, 1'b0, 1'b1, C0);

`ifdef DES_CBC_ECB_EN
        send("ecb_enc_a", 1'b1, IVX, FLAG_ENC, P0, 1'b1, 1'b1, C0);
        send("ecb_enc_b", 1'b0, '0,  FLAG_ENC, P0, 1'b1, 1'b1, C0);
        send("ecb_chain_kept", 1'b0, '0, FLAG_ENC, P0 ^ IVX, 1'b0, 1'b1, C0);
`endif

        repeat (4) @(negedge r_clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
